// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV data-memory responder.
//   state_t     : sequencing states for the core reset (LOAD / RUN / DONE)
//   region_t    : result of decoding a byte address into RAM / MMIO / nothing
//   decode_addr : address decoder shared by the core and host ports
package rv_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM    = 2'd0,
        RGN_STATUS = 2'd1,
        RGN_COUNT  = 2'd2,
        RGN_NONE   = 2'd3
    } region_t;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_2000;
    localparam logic [31:0] MMIO_CNT_OFFSET   = 32'h0000_0004;
    localparam logic [31:0] DONE_MAGIC        = 32'hDEADBEEF;

    // Byte-lane bits are ignored: every access is treated as a word access.
    // RAM is checked first so an MMIO window placed inside RAM would be shadowed.
    function automatic region_t decode_addr(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [31:0] mmio_base);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        if (word_addr < ram_bytes)
            decode_addr = RGN_RAM;
        else if (word_addr == mmio_base)
            decode_addr = RGN_STATUS;
        else if (word_addr == mmio_base + MMIO_CNT_OFFSET)
            decode_addr = RGN_COUNT;
        else
            decode_addr = RGN_NONE;
    endfunction

endpackage

// File: rtl/rv_mem_responder_if.sv
// Bus bundle between the responder and its two requesters (core DMEM port
// and host load/readback port).
//   dmem_*  : core byte-addressed access, byte write enables, registered read data
//   host_*  : host valid/ready word access, one-cycle rvalid pulse with read data
//   host_start : launch / relaunch request
// Modports: slave = responder side, master = requester side.
interface rv_mem_responder_if;

    logic [31:0] dmem_addr;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;

    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        host_start;

    modport slave (
        input  dmem_addr, dmem_en, dmem_we, dmem_din,
        output dmem_dout,
        input  host_valid, host_we, host_addr, host_wdata, host_start,
        output host_ready, host_rvalid, host_rdata
    );

    modport master (
        output dmem_addr, dmem_en, dmem_we, dmem_din,
        input  dmem_dout,
        output host_valid, host_we, host_addr, host_wdata, host_start,
        input  host_ready, host_rvalid, host_rdata
    );

endinterface

// File: rtl/bram_be.sv
// Single-port, read-first, byte-enable block RAM (32-bit words).
//   clk  : clock
//   en   : access enable; read data register only updates when en=1
//   we   : per-byte write enables (bit i -> byte i), only honoured with en=1
//   addr : word address
//   din  : write data
//   dout : registered read data (old word on a write cycle)
// Contents are never reset.
module bram_be #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    // One independent byte-wide array per lane keeps each lane a plain
    // read-first RAM with a single write port.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q_reg;

        always_ff @(posedge clk) begin
            if (en) begin
                lane_q_reg <= lane_mem[addr];
                if (we[gi])
                    lane_mem[addr] <= din[gi*8 +: 8];
            end
        end

        assign dout[gi*8 +: 8] = lane_q_reg;
    end

endmodule

// File: rtl/rv_mem_responder.sv
// Data-memory responder for the pipelined RV core.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of rv_mem_responder_if (core DMEM + host port)
//   core_rst_n : registered active-low reset to the core (released only in RUN)
//   done       : program completed (core wrote DONE_MAGIC to the status register)
// The host owns the RAM in LOAD/DONE, the core owns it in RUN. An MMIO window
// holds a status register and a free-running RUN cycle counter.
module rv_mem_responder
    import rv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    rv_mem_responder_if.slave bus,
    output logic              core_rst_n,
    output logic              done
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;

    state_t  state_reg, state_next;
    logic    core_rst_n_reg, core_rst_n_next;
    logic    host_ready_reg, host_ready_next;
    logic    done_reg, done_next;
    logic [31:0] status_reg, status_next;
    logic [31:0] cnt_reg, cnt_next;

    region_t core_rgn, host_rgn;
    logic    core_act, host_act, core_done_hit;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din, ram_dout;

    logic [31:0] core_mmio, host_mmio;
    logic        core_pend_reg, core_from_ram_reg;
    logic [31:0] core_mmio_reg, core_hold_reg, core_dout;
    logic        host_pend_reg, host_from_ram_reg;
    logic [31:0] host_mmio_reg, host_hold_reg, host_dout;

    // ------------------------------------------------------------------
    // Request qualification. rst_n gates both ports so a reset edge never
    // lets a stray write reach the RAM or the status register.
    // ------------------------------------------------------------------
    assign core_rgn = decode_addr(bus.dmem_addr, RAM_BYTES, MMIO_BASE);
    assign host_rgn = decode_addr(bus.host_addr, RAM_BYTES, MMIO_BASE);
    assign core_act = rst_n && (state_reg == ST_RUN) && bus.dmem_en;
    assign host_act = rst_n && bus.host_valid && host_ready_reg;

    assign core_done_hit = core_act && (bus.dmem_we == 4'hF) &&
                           (core_rgn == RGN_STATUS) && (bus.dmem_din == DONE_MAGIC);

    // ------------------------------------------------------------------
    // Sequencing FSM. The core reset, host_ready and done are registered
    // copies of the next state so they change on the same edge as it.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD: if (bus.host_start) state_next = ST_RUN;
            ST_RUN:  if (core_done_hit)  state_next = ST_DONE;
            ST_DONE: if (bus.host_start) state_next = ST_RUN;
            default: state_next = ST_LOAD;
        endcase
        core_rst_n_next = (state_next == ST_RUN);
        host_ready_next = (state_next != ST_RUN);
        done_next       = (state_next == ST_DONE);
    end

    // Counter reads 0 in the first RUN cycle, then counts RUN cycles.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == ST_RUN)
            cnt_next = cnt_reg + 32'd1;
        if ((state_next == ST_RUN) && (state_reg != ST_RUN))
            cnt_next = 32'd0;
    end

    always_comb begin
        status_next = status_reg;
        if (core_act && (core_rgn == RGN_STATUS)) begin
            for (int i = 0; i < 4; i++)
                if (bus.dmem_we[i])
                    status_next[i*8 +: 8] = bus.dmem_din[i*8 +: 8];
        end else if (host_act && bus.host_we && (host_rgn == RGN_STATUS)) begin
            status_next = bus.host_wdata;
        end
    end

    // ------------------------------------------------------------------
    // RAM port mux: core in RUN, host otherwise. Only RAM-region accesses
    // enable the array so MMIO / unmapped traffic leaves its output alone.
    // ------------------------------------------------------------------
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 4'h0;
        ram_addr = '0;
        ram_din  = '0;
        if (state_reg == ST_RUN) begin
            ram_en   = core_act && (core_rgn == RGN_RAM);
            ram_we   = bus.dmem_we;
            ram_addr = bus.dmem_addr[AW+1:2];
            ram_din  = bus.dmem_din;
        end else begin
            ram_en   = host_act && (host_rgn == RGN_RAM);
            ram_we   = bus.host_we ? 4'hF : 4'h0;
            ram_addr = bus.host_addr[AW+1:2];
            ram_din  = bus.host_wdata;
        end
    end

    bram_be #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_bram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .din   (ram_din),
        .dout  (ram_dout)
    );

    // MMIO read values are captured before any same-cycle write lands,
    // which gives read-first behaviour on the status register too.
    assign core_mmio = (core_rgn == RGN_STATUS) ? status_reg :
                       (core_rgn == RGN_COUNT)  ? cnt_reg    : 32'd0;
    assign host_mmio = (host_rgn == RGN_STATUS) ? status_reg :
                       (host_rgn == RGN_COUNT)  ? cnt_reg    : 32'd0;

    // Each read port shows fresh data for one cycle after its own access and
    // otherwise replays its last value, so the shared RAM output register
    // being reused by the other port never disturbs it.
    assign core_dout = core_pend_reg ? (core_from_ram_reg ? ram_dout : core_mmio_reg)
                                     : core_hold_reg;
    assign host_dout = host_pend_reg ? (host_from_ram_reg ? ram_dout : host_mmio_reg)
                                     : host_hold_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= ST_LOAD;
            core_rst_n_reg    <= 1'b0;
            host_ready_reg    <= 1'b0;
            done_reg          <= 1'b0;
            status_reg        <= 32'd0;
            cnt_reg           <= 32'd0;
            core_pend_reg     <= 1'b0;
            core_from_ram_reg <= 1'b0;
            core_mmio_reg     <= 32'd0;
            core_hold_reg     <= 32'd0;
            host_pend_reg     <= 1'b0;
            host_from_ram_reg <= 1'b0;
            host_mmio_reg     <= 32'd0;
            host_hold_reg     <= 32'd0;
        end else begin
            state_reg         <= state_next;
            core_rst_n_reg    <= core_rst_n_next;
            host_ready_reg    <= host_ready_next;
            done_reg          <= done_next;
            status_reg        <= status_next;
            cnt_reg           <= cnt_next;
            core_pend_reg     <= core_act;
            core_from_ram_reg <= (core_rgn == RGN_RAM);
            core_mmio_reg     <= core_mmio;
            core_hold_reg     <= core_dout;
            host_pend_reg     <= host_act && !bus.host_we;
            host_from_ram_reg <= (host_rgn == RGN_RAM);
            host_mmio_reg     <= host_mmio;
            host_hold_reg     <= host_dout;
        end
    end

    assign bus.dmem_dout   = core_dout;
    assign bus.host_rdata  = host_dout;
    assign bus.host_rvalid = host_pend_reg;
    assign bus.host_ready  = host_ready_reg;
    assign core_rst_n      = core_rst_n_reg;
    assign done            = done_reg;

endmodule

// File: tb/tb_rv_mem_responder.sv
// Self-checking bench for rv_mem_responder: directed scenarios plus random
// core and host traffic compared against a word-array reference model.
module tb_rv_mem_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic core_rst_n, done;

    int errors    = 0;
    int checks    = 0;
    int cyc_count = 0;
    int run_start = 0;

    // Reference model: memory image, status register, last core read data.
    logic [31:0] mem_m [1024];
    bit          known_m [1024];
    logic [31:0] status_m = 32'd0;
    logic [31:0] dout_m   = 32'd0;

    rv_mem_responder_if bus ();

    rv_mem_responder #(
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (32'h0000_2000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_count <= cyc_count + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.dmem_addr  = 32'd0;
        bus.dmem_en    = 1'b0;
        bus.dmem_we    = 4'h0;
        bus.dmem_din   = 32'd0;
        bus.host_valid = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 32'd0;
        bus.host_wdata = 32'd0;
        bus.host_start = 1'b0;
    endtask

    // 0 = RAM (4 KiB), 1 = status, 2 = cycle counter, 3 = unmapped
    function automatic int region_of(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < 32'd4096)        return 0;
        if (w == 32'h0000_2000)  return 1;
        if (w == 32'h0000_2004)  return 2;
        return 3;
    endfunction

    // Core access in RUN: returns what the read port must show next cycle
    // (old contents) and updates the model with the byte-enabled write.
    task automatic model_core(input logic [31:0] a, input logic [3:0] we,
                              input logic [31:0] d, input logic [31:0] cnt);
        int idx;
        idx = int'(a[11:2]);
        case (region_of(a))
            0: begin
                dout_m = mem_m[idx];
                for (int b = 0; b < 4; b++)
                    if (we[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
                if (we == 4'hF) known_m[idx] = 1'b1;
            end
            1: begin
                dout_m = status_m;
                for (int b = 0; b < 4; b++)
                    if (we[b]) status_m[b*8 +: 8] = d[b*8 +: 8];
            end
            2: dout_m = cnt;
            default: dout_m = 32'd0;
        endcase
    endtask

    task automatic model_host_write(input logic [31:0] a, input logic [31:0] d);
        case (region_of(a))
            0: begin mem_m[int'(a[11:2])] = d; known_m[int'(a[11:2])] = 1'b1; end
            1: status_m = d;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_host_read(input logic [31:0] a);
        case (region_of(a))
            0:       return mem_m[int'(a[11:2])];
            1:       return status_m;
            default: return 32'd0;
        endcase
    endfunction

    task automatic host_op(input bit we, input logic [31:0] a, input logic [31:0] d, input bit start);
        bus.host_valid = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_start = start;
        tick();
        bus.host_valid = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_start = 1'b0;
    endtask

    task automatic core_op(input bit en, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        bus.dmem_en   = en;
        bus.dmem_addr = a;
        bus.dmem_we   = we;
        bus.dmem_din  = d;
        tick();
        bus.dmem_en   = 1'b0;
        bus.dmem_we   = 4'h0;
    endtask

    task automatic start_run();
        bus.host_start = 1'b1;
        tick();
        bus.host_start = 1'b0;
        run_start = cyc_count;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(9, 0);
        if (k < 6)  return (32'($urandom_range(63, 8)) << 2) | 32'($urandom_range(3, 0));
        if (k == 6) return 32'h0000_2000 | 32'($urandom_range(3, 0));
        if (k == 7) return 32'h0000_2004;
        return 32'h0001_0000 + (32'($urandom_range(255, 0)) << 2);
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.dmem_dout !== 32'd0) begin errors++; $display("FAIL reset_dmem_dout: got %h want 00000000", bus.dmem_dout); end
        checks++; if (bus.host_rdata !== 32'd0) begin errors++; $display("FAIL reset_host_rdata: got %h want 00000000", bus.host_rdata); end
        checks++; if (bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_host_rvalid: got %b want 0", bus.host_rvalid); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n: got %b want 0", core_rst_n); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL reset_host_ready: got %b want 0", bus.host_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL load_host_ready: got %b want 1", bus.host_ready); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL load_core_rst_n: got %b want 0", core_rst_n); end
        status_m = 32'd0;
        dout_m   = 32'd0;
    endtask

    task automatic test_host_load();
        logic [31:0] exp;
        host_op(1'b1, 32'h10, 32'h1122_3344, 1'b0);
        model_host_write(32'h10, 32'h1122_3344);
        host_op(1'b0, 32'h10, 32'd0, 1'b0);
        checks++; if (bus.host_rvalid !== 1'b1) begin errors++; $display("FAIL host_rvalid_pulse: got %b want 1", bus.host_rvalid); end
        checks++; if (bus.host_rdata !== 32'h1122_3344) begin errors++; $display("FAIL host_read_10: got %h want 11223344", bus.host_rdata); end
        tick();
        checks++; if (bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL host_rvalid_single: got %b want 0", bus.host_rvalid); end
        // Preload the words used by random traffic.
        for (int w = 8; w < 64; w++) begin
            exp = $urandom();
            host_op(1'b1, 32'(w) << 2, exp, 1'b0);
            model_host_write(32'(w) << 2, exp);
            checks++; if (bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL host_write_rvalid: word %0d got %b want 0", w, bus.host_rvalid); end
        end
        host_op(1'b0, 32'h0000_2004, 32'd0, 1'b0);
        checks++; if (bus.host_rdata !== 32'd0) begin errors++; $display("FAIL host_counter_after_reset: got %h want 00000000", bus.host_rdata); end
        host_op(1'b0, 32'h0000_3000, 32'd0, 1'b0);
        checks++; if (bus.host_rdata !== 32'd0) begin errors++; $display("FAIL host_unmapped_read: got %h want 00000000", bus.host_rdata); end
    endtask

    task automatic test_core_rw();
        logic [31:0] exp;
        start_run();
        checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL run_core_rst_n: got %b want 1", core_rst_n); end
        checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL run_host_ready: got %b want 0", bus.host_ready); end
        model_core(32'h10, 4'b0011, 32'hAABB_CCDD, 32'(cyc_count - run_start));
        core_op(1'b1, 32'h10, 4'b0011, 32'hAABB_CCDD);
        model_core(32'h10, 4'b0000, 32'd0, 32'(cyc_count - run_start));
        core_op(1'b1, 32'h10, 4'b0000, 32'd0);
        checks++; if (bus.dmem_dout !== 32'h1122_CCDD) begin errors++; $display("FAIL core_byte_write: got %h want 1122ccdd", bus.dmem_dout); end
        // Read-during-write returns the prior word.
        exp = mem_m[8];
        model_core(32'h20, 4'hF, 32'h5A5A_0001, 32'(cyc_count - run_start));
        core_op(1'b1, 32'h20, 4'hF, 32'h5A5A_0001);
        checks++; if (bus.dmem_dout !== exp) begin errors++; $display("FAIL core_read_first: got %h want %h", bus.dmem_dout, exp); end
        core_op(1'b0, 32'h20, 4'hF, 32'hFFFF_FFFF);
        checks++; if (bus.dmem_dout !== exp) begin errors++; $display("FAIL core_dout_hold: got %h want %h", bus.dmem_dout, exp); end
        model_core(32'h20, 4'h0, 32'd0, 32'(cyc_count - run_start));
        core_op(1'b1, 32'h20, 4'h0, 32'd0);
        checks++; if (bus.dmem_dout !== 32'h5A5A_0001) begin errors++; $display("FAIL core_read_after_write: got %h want 5a5a0001", bus.dmem_dout); end
        // Unmapped write dropped, read returns 0.
        core_op(1'b1, 32'h3000, 4'hF, 32'h1234_5678);
        core_op(1'b1, 32'h3000, 4'h0, 32'd0);
        dout_m = 32'd0;
        checks++; if (bus.dmem_dout !== 32'd0) begin errors++; $display("FAIL core_unmapped_read: got %h want 00000000", bus.dmem_dout); end
        // Host is locked out while the core runs.
        host_op(1'b1, 32'h24, 32'hBAD0_BAD0, 1'b0);
        host_op(1'b0, 32'h24, 32'd0, 1'b0);
        checks++; if (bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL host_locked_in_run: got %b want 0", bus.host_rvalid); end
    endtask

    task automatic test_core_random(input int n);
        logic [31:0] a, d;
        logic [3:0]  we;
        int unsigned op;
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(3, 0);
            a  = rand_addr();
            d  = $urandom();
            if (d == 32'hDEADBEEF) d = 32'd0;
            we = (op >= 2) ? 4'($urandom_range(15, 1)) : 4'h0;
            if (op == 0) begin
                core_op(1'b0, a, 4'($urandom_range(15, 0)), d);
            end else begin
                model_core(a, we, d, 32'(cyc_count - run_start));
                core_op(1'b1, a, we, d);
            end
            checks++; if (bus.dmem_dout !== dout_m) begin errors++; $display("FAIL core_random[%0d] op=%0d addr=%h we=%h: got %h want %h", i, op, a, we, bus.dmem_dout, dout_m); end
        end
    endtask

    task automatic test_done();
        model_core(32'h2000, 4'hF, 32'hDEAD_BEEE, 32'(cyc_count - run_start));
        core_op(1'b1, 32'h2000, 4'hF, 32'hDEAD_BEEE);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_wrong_magic: got %b want 0", done); end
        checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL run_kept: got %b want 1", core_rst_n); end
        model_core(32'h2000, 4'hF, 32'hDEAD_BEEF, 32'(cyc_count - run_start));
        core_op(1'b1, 32'h2000, 4'hF, 32'hDEAD_BEEF);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_set: got %b want 1", done); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL done_core_rst_n: got %b want 0", core_rst_n); end
        checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL done_host_ready: got %b want 1", bus.host_ready); end
        // Core traffic ignored outside RUN: memory and dout untouched.
        core_op(1'b1, 32'h10, 4'hF, 32'hFFFF_0000);
        checks++; if (bus.dmem_dout !== dout_m) begin errors++; $display("FAIL core_ignored_in_done: got %h want %h", bus.dmem_dout, dout_m); end
        host_op(1'b0, 32'h2000, 32'd0, 1'b0);
        checks++; if (bus.host_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL host_status_read: got %h want deadbeef", bus.host_rdata); end
        host_op(1'b0, 32'h10, 32'd0, 1'b0);
        checks++; if (bus.host_rdata !== model_host_read(32'h10)) begin errors++; $display("FAIL host_read_10_after_run: got %h want %h", bus.host_rdata, model_host_read(32'h10)); end
        host_op(1'b0, 32'h24, 32'd0, 1'b0);
        checks++; if (bus.host_rdata !== model_host_read(32'h24)) begin errors++; $display("FAIL host_write_in_run_dropped: got %h want %h", bus.host_rdata, model_host_read(32'h24)); end
    endtask

    task automatic test_counter();
        logic [31:0] exp;
        // Host read and relaunch on the same edge.
        exp = model_host_read(32'h10);
        host_op(1'b0, 32'h10, 32'd0, 1'b1);
        run_start = cyc_count;
        checks++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== exp) begin errors++; $display("FAIL read_with_start: got rvalid=%b data=%h want 1 %h", bus.host_rvalid, bus.host_rdata, exp); end
        checks++; if (done !== 1'b0 || core_rst_n !== 1'b1) begin errors++; $display("FAIL relaunch: got done=%b core_rst_n=%b want 0 1", done, core_rst_n); end
        for (int k = 0; k < 20 && (cyc_count - run_start) < 10; k++) tick();
        model_core(32'h2004, 4'h0, 32'd0, 32'(cyc_count - run_start));
        core_op(1'b1, 32'h2004, 4'h0, 32'd0);
        checks++; if (bus.dmem_dout !== 32'd10) begin errors++; $display("FAIL counter_cycle10: got %0d want 10", bus.dmem_dout); end
        core_op(1'b1, 32'h2004, 4'hF, 32'h0000_0000);
        model_core(32'h2004, 4'h0, 32'd0, 32'(cyc_count - run_start));
        core_op(1'b1, 32'h2004, 4'h0, 32'd0);
        checks++; if (bus.dmem_dout !== dout_m) begin errors++; $display("FAIL counter_readonly: got %0d want %0d", bus.dmem_dout, dout_m); end
        model_core(32'h2000, 4'h0, 32'd0, 32'(cyc_count - run_start));
        core_op(1'b1, 32'h2000, 4'h0, 32'd0);
        checks++; if (bus.dmem_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL status_kept_on_relaunch: got %h want deadbeef", bus.dmem_dout); end
    endtask

    task automatic test_mid_run_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        status_m = 32'd0;
        dout_m   = 32'd0;
        checks++; if (done !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL midrun_reset: got done=%b core_rst_n=%b want 0 0", done, core_rst_n); end
        tick();
        checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL midrun_host_ready: got %b want 1", bus.host_ready); end
        host_op(1'b0, 32'h10, 32'd0, 1'b0);
        checks++; if (bus.host_rdata !== 32'h1122_CCDD) begin errors++; $display("FAIL ram_preserved: got %h want 1122ccdd", bus.host_rdata); end
        host_op(1'b0, 32'h2000, 32'd0, 1'b0);
        checks++; if (bus.host_rdata !== 32'd0) begin errors++; $display("FAIL status_cleared: got %h want 00000000", bus.host_rdata); end
        host_op(1'b0, 32'h2004, 32'd0, 1'b0);
        checks++; if (bus.host_rdata !== 32'd0) begin errors++; $display("FAIL counter_cleared: got %h want 00000000", bus.host_rdata); end
    endtask

    task automatic test_back_to_back(input int n);
        logic [31:0] a, d, exp;
        bit          we;
        for (int i = 0; i < n; i++) begin
            a  = rand_addr();
            if (region_of(a) == 2) a = 32'h0000_2000;
            d  = $urandom();
            we = bit'($urandom_range(1, 0));
            exp = model_host_read(a);
            host_op(we, a, d, 1'b0);
            if (we) begin
                model_host_write(a, d);
                checks++; if (bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL b2b[%0d] write addr=%h: rvalid got %b want 0", i, a, bus.host_rvalid); end
            end else begin
                checks++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== exp) begin errors++; $display("FAIL b2b[%0d] read addr=%h: got rvalid=%b data=%h want 1 %h", i, a, bus.host_rvalid, bus.host_rdata, exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_core_rw();
        test_core_random(40);
        test_done();
        test_counter();
        test_core_random(40);
        test_mid_run_reset();
        test_back_to_back(30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
